// File: rtl/modbus_tx_frame_seq_if.sv
// ---------------------------------------------------------------------------
// modbus_tx_frame_seq_if
// Bundles everything the Modbus RTU response sequencer exchanges with the
// function handler, the response DPRAM read port and the UART TX byte port.
//
//   handler_done  handler -> seq   normal response ready in DPRAM (pulse)
//   exc_start     handler -> seq   send exception response (pulse)
//   exc_code      handler -> seq   exception code
//   func_code     handler -> seq   request function code
//   addr, data    handler -> seq   request register address / data (FC 06 echo)
//   tx_quantity   handler -> seq   word count for FC 03/04
//   dpram_raddr   seq -> DPRAM     read address
//   dpram_rdata   DPRAM -> seq     read data, one cycle after dpram_raddr
//   tx_data       seq -> UART      byte to send
//   tx_valid      seq -> UART      tx_data valid
//   tx_ready      UART -> seq      byte accepted
//   busy          seq -> system    frame in progress
//   frame_done    seq -> system    pulse after the last CRC byte is accepted
//
// modport master: the sequencer's view. modport slave: the surrounding system.
// ---------------------------------------------------------------------------
interface modbus_tx_frame_seq_if;
  logic        handler_done;
  logic        exc_start;
  logic [7:0]  exc_code;
  logic [7:0]  func_code;
  logic [15:0] addr;
  logic [15:0] data;
  logic [7:0]  tx_quantity;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  modport master (
    input  handler_done, exc_start, exc_code, func_code, addr, data,
           tx_quantity, dpram_rdata, tx_ready,
    output dpram_raddr, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    output handler_done, exc_start, exc_code, func_code, addr, data,
           tx_quantity, dpram_rdata, tx_ready,
    input  dpram_raddr, tx_data, tx_valid, busy, frame_done
  );
endinterface

// File: rtl/modbus_tx_frame_seq.sv
// ---------------------------------------------------------------------------
// modbus_tx_frame_seq
// Builds the Modbus RTU response frame once the function handler has filled
// the response DPRAM (or raised an exception), streams it byte by byte to the
// UART transmitter and appends the Modbus CRC16 (low byte first).
//
// Ports:
//   clk_in  system clock (all logic on the rising edge)
//   rst_in  synchronous reset, active high; aborts any frame in progress
//   bus     modbus_tx_frame_seq_if.master: start pulses and request fields,
//           DPRAM read port, UART TX byte handshake, busy / frame_done
//
// Parameters:
//   SADDR      slave address sent as byte 0 of every frame
//   MAX_WORDS  largest word count accepted for FC 03/04 responses
// ---------------------------------------------------------------------------
module modbus_tx_frame_seq #(
  parameter logic [7:0] SADDR     = 8'h01,
  parameter logic [7:0] MAX_WORDS = 8'd4
) (
  input logic                   clk_in,
  input logic                   rst_in,
  modbus_tx_frame_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, DATA_HI, DATA_LO, CRC_LO, CRC_HI, DONE
  } state_t;

  state_t      state_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic        busy_reg;
  logic        frame_done_reg;
  logic [7:0]  dpram_raddr_reg;
  logic [15:0] crc_reg;

  // Header bytes (everything before DPRAM words / CRC) are latched at start,
  // so the request fields may change freely while the frame is sent.
  logic [7:0]  hdr_reg [0:7];
  logic [2:0]  hdr_idx_reg;
  logic [2:0]  hdr_last_reg;
  logic        is_read_reg;
  logic [7:0]  word_idx_reg;
  logic [7:0]  word_last_reg;
  // High byte of the word goes straight into tx_data_reg; only the low byte
  // has to wait for its turn.
  logic [7:0]  lo_hold_reg;

  logic        xfer;
  logic [15:0] crc_next;
  logic        is_rd_fc;
  logic        qty_ok;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign xfer     = tx_valid_reg && bus.tx_ready;
  // CRC value after the byte currently on tx_data is accepted.
  assign crc_next = crc16_byte(crc_reg, tx_data_reg);
  assign is_rd_fc = (bus.func_code == 8'h03) || (bus.func_code == 8'h04);
  assign qty_ok   = (bus.tx_quantity != 8'd0) && (bus.tx_quantity <= MAX_WORDS);

  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_valid    = tx_valid_reg;
  assign bus.busy        = busy_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.dpram_raddr = dpram_raddr_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      dpram_raddr_reg <= 8'h00;
      crc_reg         <= 16'hFFFF;
      hdr_idx_reg     <= 3'd0;
      hdr_last_reg    <= 3'd0;
      is_read_reg     <= 1'b0;
      word_idx_reg    <= 8'h00;
      word_last_reg   <= 8'h00;
      lo_hold_reg     <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        hdr_reg[k] <= 8'h00;
      end
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.exc_start || bus.handler_done) begin
            state_reg    <= HDR;
            busy_reg     <= 1'b1;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= SADDR;
            crc_reg      <= 16'hFFFF;
            hdr_idx_reg  <= 3'd0;
            hdr_last_reg <= 3'd2;
            word_idx_reg <= 8'h00;
            is_read_reg  <= 1'b0;
            hdr_reg[0]   <= SADDR;
            // Exception wins over a simultaneous handler_done.
            if (bus.exc_start) begin
              hdr_reg[1] <= bus.func_code | 8'h80;
              hdr_reg[2] <= bus.exc_code;
            end else if (is_rd_fc && qty_ok) begin
              hdr_reg[1]    <= bus.func_code;
              hdr_reg[2]    <= bus.tx_quantity << 1;
              is_read_reg   <= 1'b1;
              word_last_reg <= bus.tx_quantity - 8'd1;
            end else if (bus.func_code == 8'h06) begin
              hdr_reg[1]   <= 8'h06;
              hdr_reg[2]   <= bus.addr[15:8];
              hdr_reg[3]   <= bus.addr[7:0];
              hdr_reg[4]   <= bus.data[15:8];
              hdr_reg[5]   <= bus.data[7:0];
              hdr_last_reg <= 3'd5;
            end else if (is_rd_fc) begin
              hdr_reg[1] <= bus.func_code | 8'h80;
              hdr_reg[2] <= 8'h03;   // illegal data value (bad quantity)
            end else begin
              hdr_reg[1] <= bus.func_code | 8'h80;
              hdr_reg[2] <= 8'h01;   // illegal function
            end
          end
        end

        HDR: begin
          if (xfer) begin
            crc_reg <= crc_next;
            if (hdr_idx_reg == hdr_last_reg) begin
              if (is_read_reg) begin
                tx_valid_reg    <= 1'b0;
                dpram_raddr_reg <= word_idx_reg;
                state_reg       <= RD_REQ;
              end else begin
                tx_data_reg <= crc_next[7:0];
                state_reg   <= CRC_LO;
              end
            end else begin
              hdr_idx_reg <= hdr_idx_reg + 3'd1;
              tx_data_reg <= hdr_reg[hdr_idx_reg + 3'd1];
            end
          end
        end

        // dpram_raddr already holds the word index; the RAM registers it here.
        RD_REQ: state_reg <= RD_WAIT;

        RD_WAIT: begin
          lo_hold_reg  <= bus.dpram_rdata[7:0];
          tx_data_reg  <= bus.dpram_rdata[15:8];
          tx_valid_reg <= 1'b1;
          state_reg    <= DATA_HI;
        end

        DATA_HI: begin
          if (xfer) begin
            crc_reg     <= crc_next;
            tx_data_reg <= lo_hold_reg;
            state_reg   <= DATA_LO;
          end
        end

        DATA_LO: begin
          if (xfer) begin
            crc_reg <= crc_next;
            if (word_idx_reg == word_last_reg) begin
              tx_data_reg <= crc_next[7:0];
              state_reg   <= CRC_LO;
            end else begin
              word_idx_reg    <= word_idx_reg + 8'd1;
              dpram_raddr_reg <= word_idx_reg + 8'd1;
              tx_valid_reg    <= 1'b0;
              state_reg       <= RD_REQ;
            end
          end
        end

        CRC_LO: begin
          if (xfer) begin
            tx_data_reg <= crc_reg[15:8];
            state_reg   <= CRC_HI;
          end
        end

        CRC_HI: begin
          if (xfer) begin
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end

        DONE: state_reg <= IDLE;

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_tx_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_modbus_tx_frame_seq
// Table of directed frames, a few multi-cycle corner sequences (busy-time
// start pulse, mid-frame reset) and randomized frames checked against a
// byte-list reference model of the Modbus RTU response rules.
// ---------------------------------------------------------------------------
module tb_modbus_tx_frame_seq;
  localparam logic [7:0] SADDR = 8'h01;
  localparam int         MAXW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modbus_tx_frame_seq_if bus_if ();

  modbus_tx_frame_seq #(
    .SADDR     (SADDR),
    .MAX_WORDS (8'd4)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  // Response DPRAM read port: registered read.
  logic [15:0] mem [0:255];
  always @(posedge clk) bus_if.dpram_rdata <= mem[bus_if.dpram_raddr];

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference model: lists the frame bytes from the protocol rules, then
  // appends the CRC computed bit-serially over that list.
  function automatic void model_frame(input bit ex, input logic [7:0] fc, input logic [7:0] ec,
                                      input logic [15:0] a, input logic [15:0] d,
                                      input logic [7:0] q);
    logic [15:0] crc;
    logic [7:0]  b;
    logic        fb;
    int          n;
    n = int'(q);
    exp_q.delete();
    exp_q.push_back(SADDR);
    if (ex) begin
      exp_q.push_back(fc | 8'h80);
      exp_q.push_back(ec);
    end else if (fc == 8'h03 || fc == 8'h04) begin
      if (n >= 1 && n <= MAXW) begin
        exp_q.push_back(fc);
        exp_q.push_back(8'(2 * n));
        for (int i = 0; i < n; i++) begin
          exp_q.push_back(mem[i][15:8]);
          exp_q.push_back(mem[i][7:0]);
        end
      end else begin
        exp_q.push_back(fc | 8'h80);
        exp_q.push_back(8'h03);
      end
    end else if (fc == 8'h06) begin
      exp_q.push_back(8'h06);
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end else begin
      exp_q.push_back(fc | 8'h80);
      exp_q.push_back(8'h01);
    end
    crc = 16'hFFFF;
    foreach (exp_q[i]) begin
      b = exp_q[i];
      for (int j = 0; j < 8; j++) begin
        fb  = crc[0] ^ b[j];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
    end
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
  endfunction

  // Starts one frame, collects it and checks it against exp_q.
  task automatic run_frame(input string tag, input bit hd, input bit ex,
                           input logic [7:0] fc, input logic [7:0] ec,
                           input logic [15:0] a, input logic [15:0] d, input logic [7:0] q,
                           input bit rnd, input int inject_at, input bit chk_raddr);
    int cycles = 0, done_cnt = 0, busy_bad = 0, stall_bad = 0;
    int gap_bad = 0, raddr_bad = 0, post_bad = 0, gap = 0, bad_idx;
    bit prev_stall = 0, injected = 0, timed_out = 0, ready, bytes_ok;
    logic [7:0] prev_data = 8'h00, raddr0;

    got_q.delete();
    bus_if.handler_done = hd;
    bus_if.exc_start    = ex;
    bus_if.func_code    = fc;
    bus_if.exc_code     = ec;
    bus_if.addr         = a;
    bus_if.data         = d;
    bus_if.tx_quantity  = q;
    bus_if.tx_ready     = 1'b0;
    @(negedge clk);
    bus_if.handler_done = 1'b0;
    bus_if.exc_start    = 1'b0;
    bus_if.func_code    = 8'($urandom);
    bus_if.exc_code     = 8'($urandom);
    bus_if.addr         = 16'($urandom);
    bus_if.data         = 16'($urandom);
    bus_if.tx_quantity  = 8'($urandom);
    check({tag, "_start"}, 32'({bus_if.busy, bus_if.tx_valid, bus_if.tx_data}),
          32'({1'b1, 1'b1, SADDR}));
    raddr0 = bus_if.dpram_raddr;

    while (1) begin
      bus_if.handler_done = 1'b0;
      if (prev_stall && (!bus_if.tx_valid || bus_if.tx_data !== prev_data)) stall_bad++;
      if (bus_if.frame_done) begin
        done_cnt++;
        if (bus_if.busy) busy_bad++;
        break;
      end
      if (!bus_if.busy) busy_bad++;
      if (!bus_if.tx_valid) begin
        gap++;
        if (gap > 2) gap_bad++;
      end else begin
        gap = 0;
      end
      if (chk_raddr && bus_if.dpram_raddr !== raddr0) raddr_bad++;
      ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus_if.tx_ready = ready;
      if (bus_if.tx_valid && ready) begin
        got_q.push_back(bus_if.tx_data);
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus_if.tx_valid;
      end
      prev_data = bus_if.tx_data;
      if (inject_at >= 0 && !injected && got_q.size() == inject_at) begin
        bus_if.handler_done = 1'b1;
        bus_if.func_code    = 8'h03;
        bus_if.tx_quantity  = 8'd1;
        injected = 1'b1;
      end
      @(negedge clk);
      cycles++;
      if (cycles > 400) begin
        timed_out = 1'b1;
        break;
      end
    end

    bus_if.handler_done = 1'b0;
    bus_if.tx_ready     = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.frame_done || bus_if.busy || bus_if.tx_valid) post_bad++;
    end

    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    checks++;
    bytes_ok = (got_q.size() == exp_q.size());
    bad_idx  = -1;
    if (bytes_ok) begin
      foreach (exp_q[i]) begin
        if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
      end
      bytes_ok = (bad_idx < 0);
    end
    if (!bytes_ok) begin
      failures++;
      if (bad_idx < 0) bad_idx = 0;
      $display("FAIL %s_bytes: got len %0d byte[%0d]=%02h, expected len %0d byte[%0d]=%02h",
               tag, got_q.size(), bad_idx, (bad_idx < got_q.size()) ? got_q[bad_idx] : 8'h00,
               exp_q.size(), bad_idx, (bad_idx < exp_q.size()) ? exp_q[bad_idx] : 8'h00);
    end
    check({tag, "_frame_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy"},       32'(busy_bad), 32'd0);
    check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    check({tag, "_byte_gap"},   32'(gap_bad), 32'd0);
    check({tag, "_after_done"}, 32'(post_bad), 32'd0);
    if (chk_raddr) check({tag, "_raddr_const"}, 32'(raddr_bad), 32'd0);
  endtask

  typedef struct {
    bit           hd;
    bit           ex;
    logic [7:0]   fc;
    logic [7:0]   ec;
    logic [15:0]  a;
    logic [15:0]  d;
    logic [7:0]   q;
    logic [63:0]  words;      // DPRAM[0..3], word 0 in the top 16 bits
    bit           rnd;        // random tx_ready
    bit           from_model; // expected bytes from the reference model
    int           len;
    logic [103:0] exp;        // expected bytes, byte 0 in the top 8 bits
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rst_xfers, rst_cycles, rst_bad;
    bit ex, hd, rnd;
    logic [7:0] fc, ec, q;
    logic [15:0] a, d;

    vecs[0] = '{1'b1, 1'b0, 8'h03, 8'h00, 16'h0000, 16'h0000, 8'd1, 64'h0001_0000_0000_0000,
                1'b0, 1'b0, 7, {8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84, 48'h0}};
    vecs[1] = '{1'b1, 1'b0, 8'h06, 8'h00, 16'h0001, 16'h0003, 8'd0, 64'h0,
                1'b0, 1'b0, 8, {8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B, 40'h0}};
    vecs[2] = '{1'b0, 1'b1, 8'h03, 8'h02, 16'h0000, 16'h0000, 8'd1, 64'h0,
                1'b0, 1'b0, 5, {8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 64'h0}};
    vecs[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 16'h0000, 16'h0000, 8'd4, 64'h1111_2222_3333_4444,
                1'b1, 1'b1, 13, 104'h0};
    vecs[4] = '{1'b1, 1'b0, 8'h04, 8'h00, 16'h0000, 16'h0000, 8'd5, 64'h0,
                1'b0, 1'b0, 5, {8'h01, 8'h84, 8'h03, 8'h03, 8'h01, 64'h0}};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 16'h0000, 16'h0000, 8'd1, 64'h0,
                1'b0, 1'b0, 5, {8'h01, 8'h90, 8'h01, 8'h8D, 8'hC0, 64'h0}};
    vecs[6] = '{1'b1, 1'b1, 8'h03, 8'h02, 16'h0000, 16'h0000, 8'd1, 64'h0001_0000_0000_0000,
                1'b0, 1'b0, 5, {8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 64'h0}};
    vecs[7] = '{1'b1, 1'b0, 8'h03, 8'h00, 16'h0000, 16'h0000, 8'd0, 64'h0,
                1'b1, 1'b1, 5, 104'h0};

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    bus_if.handler_done = 1'b0;
    bus_if.exc_start    = 1'b0;
    bus_if.exc_code     = 8'h00;
    bus_if.func_code    = 8'h00;
    bus_if.addr         = 16'h0000;
    bus_if.data         = 16'h0000;
    bus_if.tx_quantity  = 8'h00;
    bus_if.tx_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_raddr",      32'(bus_if.dpram_raddr), 32'd0);
    check("reset_tx_data",    32'(bus_if.tx_data),     32'd0);
    check("reset_tx_valid",   32'(bus_if.tx_valid),    32'd0);
    check("reset_busy",       32'(bus_if.busy),        32'd0);
    check("reset_frame_done", 32'(bus_if.frame_done),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 4; w++) mem[w] = vecs[i].words[63 - 16 * w -: 16];
      if (vecs[i].from_model) begin
        model_frame(vecs[i].ex, vecs[i].fc, vecs[i].ec, vecs[i].a, vecs[i].d, vecs[i].q);
      end else begin
        exp_q.delete();
        for (int k = 0; k < vecs[i].len; k++) exp_q.push_back(vecs[i].exp[103 - 8 * k -: 8]);
      end
      run_frame($sformatf("vec%0d", i), vecs[i].hd, vecs[i].ex, vecs[i].fc, vecs[i].ec,
                vecs[i].a, vecs[i].d, vecs[i].q, vecs[i].rnd, -1,
                (vecs[i].fc == 8'h06) && !vecs[i].ex);
    end

    // Start pulse while busy must be ignored (no second frame afterwards).
    mem[0] = 16'hBEEF;
    mem[1] = 16'h1234;
    model_frame(1'b0, 8'h03, 8'h00, 16'h0, 16'h0, 8'd2);
    run_frame("busy_ignore", 1'b1, 1'b0, 8'h03, 8'h00, 16'h0, 16'h0, 8'd2, 1'b0, 2, 1'b0);

    // Reset while byte 3 is presented aborts the frame without frame_done.
    bus_if.handler_done = 1'b1;
    bus_if.func_code    = 8'h03;
    bus_if.tx_quantity  = 8'd4;
    bus_if.tx_ready     = 1'b1;
    @(negedge clk);
    bus_if.handler_done = 1'b0;
    rst_xfers  = 0;
    rst_cycles = 0;
    while (!(rst_xfers == 3 && bus_if.tx_valid) && rst_cycles < 50) begin
      if (bus_if.tx_valid) rst_xfers++;
      @(negedge clk);
      rst_cycles++;
    end
    check("rst_reach_byte3", 32'(rst_cycles < 50), 32'd1);
    bus_if.tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_busy",     32'(bus_if.busy),     32'd0);
    rst_bad = 0;
    bus_if.tx_ready = 1'b1;
    repeat (20) begin
      if (bus_if.frame_done || bus_if.tx_valid || bus_if.busy) rst_bad++;
      @(negedge clk);
    end
    check("rst_no_frame", 32'(rst_bad), 32'd0);

    // Randomized frames against the reference model.
    for (int t = 0; t < 40; t++) begin
      ex  = ($urandom_range(0, 4) == 0);
      hd  = !ex || ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0:       fc = 8'h03;
        1:       fc = 8'h04;
        2:       fc = 8'h06;
        3:       fc = 8'($urandom);
        default: fc = 8'h03;
      endcase
      q   = 8'($urandom_range(0, 6));
      ec  = 8'($urandom);
      a   = 16'($urandom);
      d   = 16'($urandom);
      rnd = ($urandom_range(0, 1) == 1);
      for (int w = 0; w < 8; w++) mem[w] = 16'($urandom);
      model_frame(ex, fc, ec, a, d, q);
      run_frame($sformatf("rnd%0d", t), hd, ex, fc, ec, a, d, q, rnd, -1,
                !ex && (fc == 8'h06));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
